// File: rtl/fpr_cdb_arbiter.sv
// fpr_cdb_arbiter: grants at most one FPR-producing unit per cycle and
// reserves the CDB slot that the unit's fixed-latency core will fill.
// The reserved slot later broadcasts the tag and data on the FPR CDB.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   req_valid    per-unit request (oldest ready entry)
//   req_ready    one-hot grant, combinational from req_valid and state
//   req_tag      per-unit ROB tag of the entry being dispatched
//   unit_result  per-unit core output, valid LAT[u] cycles after grant
//   cdb_valid    CDB broadcast valid
//   cdb_tag      CDB broadcast ROB tag
//   cdb_data     CDB broadcast result
module fpr_cdb_arbiter #(
  parameter int N_UNIT    = 4,
  parameter int ROB_WIDTH = 4,
  parameter int MAX_LAT   = 4,
  parameter int LAT [N_UNIT] = '{1, 2, 3, 4}
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_UNIT-1:0]                req_valid,
  output logic [N_UNIT-1:0]                req_ready,
  input  logic [N_UNIT-1:0][ROB_WIDTH-1:0] req_tag,
  input  logic [N_UNIT-1:0][31:0]          unit_result,
  output logic                             cdb_valid,
  output logic [ROB_WIDTH-1:0]             cdb_tag,
  output logic [31:0]                      cdb_data
);

  localparam int UW = (N_UNIT > 1) ? $clog2(N_UNIT) : 1;
  localparam int SW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [UW-1:0]        src;
  } slot_t;

  // slot[k] is the CDB broadcast k cycles from now
  slot_t slot [MAX_LAT];

  logic [UW-1:0]     rr_ptr;
  logic [UW-1:0]     win;
  logic [UW-1:0]     idx;
  logic              found;
  logic [N_UNIT-1:0] elig;
  logic [SW-1:0]     wr_idx;

  // A unit may go only if the slot it will land in (after this edge's shift)
  // is free. slot[LAT[u]] shifts into slot[LAT[u]-1]; the deepest latency
  // always writes the freshly emptied top slot, so it never conflicts.
  for (genvar u = 0; u < N_UNIT; u++) begin : g_elig
    if (LAT[u] >= MAX_LAT) begin : g_top
      assign elig[u] = req_valid[u] & ~reset;
    end else begin : g_mid
      assign elig[u] = req_valid[u] & ~reset & ~slot[LAT[u]].valid;
    end
  end

  // Round-robin scan starting at rr_ptr
  always_comb begin
    found     = 1'b0;
    win       = '0;
    idx       = '0;
    wr_idx    = '0;
    req_ready = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      idx = UW'((int'(rr_ptr) + i) % N_UNIT);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      req_ready[win] = 1'b1;
      for (int u = 0; u < N_UNIT; u++)
        if (win == UW'(u)) wr_idx = SW'(LAT[u] - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MAX_LAT; k++) slot[k] <= '0;
      rr_ptr <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT - 1; k++) slot[k] <= slot[k+1];
      slot[MAX_LAT-1] <= '0;
      // Overrides the shift into wr_idx; eligibility guarantees it was empty
      if (found) begin
        slot[wr_idx] <= '{valid: 1'b1, tag: req_tag[win], src: win};
        rr_ptr       <= UW'((int'(win) + 1) % N_UNIT);
      end
    end
  end

  assign cdb_valid = slot[0].valid;
  assign cdb_tag   = slot[0].tag;
  assign cdb_data  = unit_result[slot[0].src];

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Directed bench for fpr_cdb_arbiter. Instance dut uses the default
// latencies {1,2,3,4}; instance dut_b uses equal latencies {2,2,2,2} for the
// round-robin throughput case. Inputs change 1 time unit after the rising
// edge and outputs are sampled 1 unit later.
module tb_fpr_cdb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [3:0]       req_valid, req_valid_b, req_ready, req_ready_b;
  logic [3:0][3:0]  req_tag;
  logic [3:0][31:0] unit_result;
  logic             cdb_valid, cdb_valid_b;
  logic [3:0]       cdb_tag, cdb_tag_b;
  logic [31:0]      cdb_data, cdb_data_b;

  int checks = 0;
  int failures = 0;

  fpr_cdb_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .unit_result(unit_result),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  fpr_cdb_arbiter #(.MAX_LAT(2), .LAT('{2, 2, 2, 2})) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_tag(req_tag), .unit_result(unit_result),
    .cdb_valid(cdb_valid_b), .cdb_tag(cdb_tag_b), .cdb_data(cdb_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected broadcast on dut: valid, and if valid the tag and unit u's result
  task automatic cdb_is(input string n, input logic v, input int tag, input int u);
    chk({n, "_v"}, 32'(cdb_valid), 32'(v));
    if (v) begin
      chk({n, "_tag"}, 32'(cdb_tag), 32'(tag));
      chk({n, "_data"}, cdb_data, 32'hA000_0000 + 32'(u));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mixed-latency hand table: grants and broadcasting unit (-1 = none)
  logic [3:0] mg [11] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000,
                          4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  int         mu [11] = '{-1, -1, 1, -1, 2, 1, 3, 2, -1, 3, -1};

  initial begin
    reset       = 1'b1;
    req_valid   = '1;
    req_valid_b = '1;
    for (int u = 0; u < 4; u++) begin
      req_tag[u]     = 4'(u + 8);
      unit_result[u] = 32'hA000_0000 + 32'(u);
    end

    // reset: no grant even with all requests up
    cyc(); cyc(); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ready_b", 32'(req_ready_b), 32'h0);

    // round robin, equal latency 2: grants 0,1,2,3,..; CDB full from cycle 2
    cyc(); reset = 1'b0; req_valid = '0; #1;
    chk("rst_cdb", 32'(cdb_valid), 32'h0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin cyc(); #1; end
      chk("rr_grant", 32'(req_ready_b), 32'(4'b0001 << (c % 4)));
      chk("rr_cdb_v", 32'(cdb_valid_b), (c >= 2) ? 32'h1 : 32'h0);
      if (c >= 2) begin
        chk("rr_cdb_tag", 32'(cdb_tag_b), 32'(8 + (c - 2) % 4));
        chk("rr_cdb_data", cdb_data_b, 32'hA000_0000 + 32'((c - 2) % 4));
      end
    end
    cyc(); req_valid_b = '0;

    // single request: unit2 (LAT 3) tag 5, broadcast 3 cycles later only
    cyc(); req_valid = 4'b0100; req_tag[2] = 4'd5; #1;
    chk("single_grant", 32'(req_ready), 32'h4);
    cdb_is("single_c0", 1'b0, 0, 0);
    cyc(); req_valid = '0; #1; cdb_is("single_c1", 1'b0, 0, 0);
    cyc(); #1; cdb_is("single_c2", 1'b0, 0, 0);
    cyc(); #1; cdb_is("single_c3", 1'b1, 5, 2);
    cyc(); #1; cdb_is("single_c4", 1'b0, 0, 0);
    req_tag[2] = 4'd10;

    // collision: unit3 (LAT 4) at c0 blocks unit0 (LAT 1) at c3
    cyc(); req_valid = 4'b1000; req_tag[3] = 4'd7; #1;
    chk("col_grant3", 32'(req_ready), 32'h8);
    cyc(); req_valid = '0;
    cyc();
    cyc(); req_valid = 4'b0001; req_tag[0] = 4'd9; #1;
    chk("col_blocked", 32'(req_ready), 32'h0);
    cdb_is("col_c3", 1'b0, 0, 0);
    cyc(); #1;
    chk("col_grant0", 32'(req_ready), 32'h1);
    cdb_is("col_c4", 1'b1, 7, 3);
    cyc(); req_valid = '0; #1; cdb_is("col_c5", 1'b1, 9, 0);
    cyc(); #1; cdb_is("col_c6", 1'b0, 0, 0);
    req_tag[3] = 4'd11; req_tag[0] = 4'd8;

    // idle: nothing moves
    for (int c = 0; c < 8; c++) begin
      cyc(); #1;
      chk("idle_ready", 32'(req_ready), 32'h0);
      chk("idle_cdb", 32'(cdb_valid), 32'h0);
    end

    // mixed latencies, all valid for 6 cycles starting at rr_ptr=1
    for (int c = 0; c < 11; c++) begin
      cyc(); req_valid = (c < 6) ? 4'b1111 : 4'b0000; #1;
      chk("mix_grant", 32'(req_ready), 32'(mg[c]));
      cdb_is("mix", mu[c] >= 0, 8 + mu[c], mu[c]);
    end

    // reset mid-flight discards unit3 and unit1 broadcasts, rr_ptr back to 0
    cyc(); req_valid = 4'b1000; #1;
    chk("mf_grant3", 32'(req_ready), 32'h8);
    cyc(); req_valid = 4'b0010; #1;
    chk("mf_grant1", 32'(req_ready), 32'h2);
    cyc(); reset = 1'b1; req_valid = 4'b1111; #1;
    chk("mf_rst_ready", 32'(req_ready), 32'h0);
    cyc(); reset = 1'b0; req_valid = '0; #1; cdb_is("mf_c3", 1'b0, 0, 0);
    cyc(); #1; cdb_is("mf_c4", 1'b0, 0, 0);
    cyc(); req_valid = 4'b1111; #1;
    chk("mf_rr0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0; #1; cdb_is("mf_c6", 1'b1, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
